// File: rtl/mips_pkg.sv
// Shared MIPS-16 constants used by fetch, decode and control.
// Opcode/function codes and fetch state encodings live here.
package mips_pkg;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 3;

    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    localparam logic [3:0] OP_R   = 4'b0000;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_J   = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;

    localparam logic [2:0] FCODE_JR = 3'd7;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_SILENCE
    } fetch_state_t;

endpackage

// File: rtl/ctrl_xfer_detect.sv
// Flags instructions that change control flow (beq, j, jal, jr).
// Purely combinational; the caller qualifies with instr_valid.
module ctrl_xfer_detect
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic               is_ctrl_xfer
);

    logic [3:0] opcode;
    logic [2:0] fcode;

    assign opcode = instr[15:12];
    assign fcode  = instr[2:0];

    always_comb begin
        is_ctrl_xfer = 1'b0;
        unique case (opcode)
            OP_BEQ, OP_J, OP_JAL: is_ctrl_xfer = 1'b1;
            OP_R:    is_ctrl_xfer = (fcode == FCODE_JR);
            default: is_ctrl_xfer = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ROM interface and post-branch NOP window.
// A redirect ends the window early; stall replays the held word.
module fetch_unit #(
    parameter int unsigned       ADDR_W         = 12,
    parameter logic [ADDR_W-1:0] BOOT_ADDR      = '0,
    parameter int unsigned       SILENCE_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          rom_rd,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [mips_pkg::INSTR_W-1:0]  rom_data,
    output logic [mips_pkg::INSTR_W-1:0]  instr,
    output logic                          instr_valid,
    output logic [ADDR_W-1:0]             instr_pc,
    input  logic                          stall,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_target
);
    import mips_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              live_q, live_d;
    logic              is_ctrl;
    logic              xfer;

    ctrl_xfer_detect u_cxd (
        .instr        (instr),
        .is_ctrl_xfer (is_ctrl)
    );

    assign instr       = live_q ? rom_data : NOP;
    assign instr_valid = live_q && (state_q != ST_BOOT);
    assign instr_pc    = ipc_q;
    assign xfer        = instr_valid && is_ctrl;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ipc_d    = ipc_q;
        cnt_d    = cnt_q;
        live_d   = live_q;
        rom_rd   = 1'b0;
        rom_addr = pc_q;
        if (state_q != ST_BOOT) begin
            rom_rd = 1'b1;
            // Replay the held word so instr stays stable while stalled
            if (stall && !redirect) rom_addr = ipc_q;
        end
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_SILENCE: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    live_d  = 1'b0;
                end else if (stall) begin
                    state_d = state_q;
                end else if (state_q == ST_SILENCE) begin
                    ipc_d = pc_q;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        pc_d    = pc_q + 1'b1;
                        cnt_d   = '0;
                        live_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (xfer) begin
                    state_d = ST_SILENCE;
                    ipc_d   = pc_q;
                    cnt_d   = CNT_W'(SILENCE_CYCLES);
                    live_d  = 1'b0;
                end else begin
                    pc_d   = pc_q + 1'b1;
                    ipc_d  = pc_q;
                    live_d = 1'b1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= BOOT_ADDR;
            ipc_q   <= '0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
        end
    end

endmodule
